// File: rtl/wb_host_master.sv
// -----------------------------------------------------------------------------
// wb_host_master
//
// Wishbone classic single-transfer initiator. Each request accepted on the
// valid/ready request port becomes exactly one Wishbone cycle. Its result comes
// back on the valid/ready response port. A watchdog ends a cycle that the
// slave never acknowledges, and flags it with rsp_err.
//
// Handshake semantics (both request and response ports): a transfer happens
// on a rising clk edge where valid and ready are both 1. A producer holds
// valid and its payload stable until that edge. Ready never depends
// combinationally on valid, because every output here is a register.
//
// Ports
//   clk        clock, rising-edge
//   rst        asynchronous active-low reset
//   req_valid / req_ready / req_we / req_adr / req_dat   request channel
//   rsp_valid / rsp_ready / rsp_dat / rsp_err            response channel
//   wb_adr_o / wb_dat_o / wb_we_o / wb_stb_o / wb_cyc_o  Wishbone outputs
//   wb_dat_i / wb_ack_i                                  Wishbone inputs
//   busy       high while in BUS or RESP
//   dbg_state  current FSM state (0 IDLE, 1 BUS, 2 RESP)
// -----------------------------------------------------------------------------
module wb_host_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_adr,
    input  logic [DATA_WIDTH-1:0] req_dat,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_dat,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_we_o,
    output logic                  wb_stb_o,
    output logic                  wb_cyc_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // A zero TIMEOUT disables the watchdog. The counter then only needs one bit,
    // and it saturates instead of wrapping.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  req_ready_nxt;
    logic                  rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_dat_nxt;
    logic                  rsp_err_nxt;
    logic [ADDR_WIDTH-1:0] wb_adr_nxt;
    logic [DATA_WIDTH-1:0] wb_dat_nxt;
    logic                  wb_we_nxt;
    logic                  wb_stb_nxt;
    logic                  wb_cyc_nxt;
    logic                  busy_nxt;
    logic                  timeout_hit;

    assign dbg_state   = state;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_dat   <= rsp_dat_nxt;
            rsp_err   <= rsp_err_nxt;
            wb_adr_o  <= wb_adr_nxt;
            wb_dat_o  <= wb_dat_nxt;
            wb_we_o   <= wb_we_nxt;
            wb_stb_o  <= wb_stb_nxt;
            wb_cyc_o  <= wb_cyc_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        // By default every register holds its value. That gives the required
        // stability of the bus signals in BUS and of the response in RESP.
        state_nxt     = state;
        cnt_nxt       = cnt;
        req_ready_nxt = req_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_dat_nxt   = rsp_dat;
        rsp_err_nxt   = rsp_err;
        wb_adr_nxt    = wb_adr_o;
        wb_dat_nxt    = wb_dat_o;
        wb_we_nxt     = wb_we_o;
        wb_stb_nxt    = wb_stb_o;
        wb_cyc_nxt    = wb_cyc_o;
        busy_nxt      = busy;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    wb_adr_nxt    = req_adr;
                    wb_dat_nxt    = req_dat;
                    wb_we_nxt     = req_we;
                    wb_cyc_nxt    = 1'b1;
                    wb_stb_nxt    = 1'b1;
                    req_ready_nxt = 1'b0;
                    busy_nxt      = 1'b1;
                    cnt_nxt       = '0;
                    state_nxt     = BUS;
                end
            end

            BUS: begin
                if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
                // Ack is checked first, so an ack on the watchdog's last
                // cycle still completes the transfer without an error.
                if (wb_ack_i) begin
                    wb_cyc_nxt    = 1'b0;
                    wb_stb_nxt    = 1'b0;
                    wb_we_nxt     = 1'b0;
                    rsp_dat_nxt   = wb_we_o ? '0 : wb_dat_i;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if (timeout_hit) begin
                    wb_cyc_nxt    = 1'b0;
                    wb_stb_nxt    = 1'b0;
                    wb_we_nxt     = 1'b0;
                    rsp_dat_nxt   = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end
            end

            RESP: begin
                // wb_ack_i is not looked at here. A lingering ack from the
                // slave therefore cannot start or end anything.
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    rsp_err_nxt   = 1'b0;
                    rsp_dat_nxt   = '0;
                    req_ready_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                state_nxt     = IDLE;
                req_ready_nxt = 1'b1;
                rsp_valid_nxt = 1'b0;
                rsp_err_nxt   = 1'b0;
                wb_cyc_nxt    = 1'b0;
                wb_stb_nxt    = 1'b0;
                wb_we_nxt     = 1'b0;
                busy_nxt      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_host_master.sv
// -----------------------------------------------------------------------------
// tb_wb_host_master
//
// Directed bench for wb_host_master. Two instances are used:
//   dut  - TIMEOUT=8, wired to a registered memory slave model
//   dut4 - TIMEOUT=4, driven by hand to race an ack against the watchdog
// Expected responses are pushed to exp_q when a request is issued. They are
// popped and compared when the response appears.
// -----------------------------------------------------------------------------
module tb_wb_host_master;

    localparam int DW = 32;
    localparam int AW = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dut (TIMEOUT=8) ----------------
    logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [AW-1:0] req_adr = '0;
    logic [DW-1:0] req_dat = '0;
    logic          req_ready, rsp_valid, rsp_err, wb_we_o, wb_stb_o, wb_cyc_o, busy;
    logic [DW-1:0] rsp_dat, wb_dat_o, wb_dat_i;
    logic [AW-1:0] wb_adr_o;
    logic          wb_ack_i;
    logic [1:0]    dbg_state;

    wb_host_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- dut4 (TIMEOUT=4) ----------------
    logic          r4_valid = 1'b0, r4_we = 1'b0, p4_ready = 1'b0, w4_ack = 1'b0;
    logic [AW-1:0] r4_adr = '0;
    logic [DW-1:0] r4_dat = '0, w4_dat_i = '0;
    logic          r4_ready, p4_valid, p4_err, w4_we, w4_stb, w4_cyc, busy4;
    logic [DW-1:0] p4_dat, w4_dat;
    logic [AW-1:0] w4_adr;
    logic [1:0]    state4;

    wb_host_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(r4_valid), .req_ready(r4_ready), .req_we(r4_we),
        .req_adr(r4_adr), .req_dat(r4_dat),
        .rsp_valid(p4_valid), .rsp_ready(p4_ready), .rsp_dat(p4_dat), .rsp_err(p4_err),
        .wb_adr_o(w4_adr), .wb_dat_o(w4_dat), .wb_we_o(w4_we),
        .wb_stb_o(w4_stb), .wb_cyc_o(w4_cyc),
        .wb_dat_i(w4_dat_i), .wb_ack_i(w4_ack),
        .busy(busy4), .dbg_state(state4)
    );

    // ---------------- memory slave model (ack one cycle after stb) ----------------
    logic          slave_on = 1'b1;
    logic          stretch  = 1'b0;
    logic          held;
    logic [DW-1:0] mem [0:1023];
    logic          ack_q;
    logic [DW-1:0] rdata_q;

    assign wb_ack_i = ack_q;
    assign wb_dat_i = rdata_q;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q   <= 1'b0;
            held    <= 1'b0;
            rdata_q <= '0;
        end else if (ack_q && stretch && !held) begin
            held <= 1'b1;                 // keep ack one extra cycle
        end else begin
            held  <= 1'b0;
            ack_q <= slave_on && wb_cyc_o && wb_stb_o && !ack_q;
            if (slave_on && wb_cyc_o && wb_stb_o && !ack_q) begin
                rdata_q <= mem[wb_adr_o];
                if (wb_we_o) mem[wb_adr_o] <= wb_dat_o;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW:0]   exp_q[$];               // {err, dat}
    int            total = 0;
    int            bad   = 0;
    logic [AW-1:0] cur_adr;
    logic [DW-1:0] cur_dat;
    logic          cur_we;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic exp_err, input logic [DW-1:0] exp_dat);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_issue", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat;
        cur_we = we; cur_adr = adr; cur_dat = dat;
        exp_q.push_back({exp_err, exp_dat});
        @(negedge clk);
        // Garbage on the request inputs after accept must be ignored.
        req_valid = 1'b0; req_we = ~we; req_adr = ~adr; req_dat = $urandom;
        chk("cyc_stb_after_accept", {wb_cyc_o, wb_stb_o, req_ready, busy}, 4'b1101);
        chk("adr_after_accept", wb_adr_o, adr);
        chk("dat_we_after_accept", {wb_we_o, wb_dat_o}, {we, dat});
    endtask

    task automatic wait_rsp(input int exp_cyc);
        int cyc_cnt = 0;
        int lim = 0;
        logic stable = 1'b1;
        while (!rsp_valid && lim < 100) begin
            if (wb_cyc_o) cyc_cnt++;
            if (!(wb_cyc_o && wb_stb_o && wb_adr_o == cur_adr && wb_dat_o == cur_dat
                  && wb_we_o == cur_we)) stable = 1'b0;
            @(negedge clk);
            lim++;
        end
        chk("rsp_valid_seen", rsp_valid, 1);
        chk("bus_signals_stable", stable, 1);
        chk("cyc_high_cycles", cyc_cnt, exp_cyc);
        chk("rsp_latency", lim, exp_cyc);
        chk("bus_released", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    endtask

    task automatic take_rsp(input int hold);
        logic [DW-1:0] d0;
        logic          e0;
        logic          ok = 1'b1;
        logic [DW:0]   exp;
        d0 = rsp_dat;
        e0 = rsp_err;
        for (int i = 0; i < hold; i++) begin
            if (!(rsp_valid && rsp_dat == d0 && rsp_err == e0 && !req_ready
                  && !wb_cyc_o && !wb_stb_o)) ok = 1'b0;
            @(negedge clk);
        end
        chk("rsp_held_under_backpressure", ok, 1);
        chk("scoreboard_nonempty", exp_q.size() > 0, 1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk("rsp_err", rsp_err, exp[DW]);
        chk("rsp_dat", rsp_dat, exp[DW-1:0]);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("after_rsp_handshake", {rsp_valid, rsp_err, req_ready, busy, wb_cyc_o}, 5'b00100);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        int            n;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {req_ready, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o, busy},
            7'b1000000);
        chk("reset_rsp_dat", rsp_dat, 0);
        chk("reset_state", dbg_state, 0);
        chk("reset_dut4", {r4_ready, p4_valid, w4_cyc, busy4}, 4'b1000);
        rst = 1'b1;
        @(negedge clk);

        // Write 0xDEADBEEF to 0x004: cyc 2 cycles, rsp_dat 0
        issue(1'b1, 10'h004, 32'hDEAD_BEEF, 1'b0, 32'h0);
        wait_rsp(2);
        take_rsp(0);

        // Read back 0x004
        issue(1'b0, 10'h004, 32'h0, 1'b0, 32'hDEAD_BEEF);
        wait_rsp(2);
        take_rsp(0);

        // Read of an untouched location
        issue(1'b0, 10'h020, 32'h0, 1'b0, 32'hA500_0020);
        wait_rsp(2);
        take_rsp(1);

        // Timeout: slave silent, cyc high exactly 8 cycles
        slave_on = 1'b0;
        issue(1'b0, 10'h010, 32'h0, 1'b1, 32'h0);
        wait_rsp(8);
        take_rsp(0);
        slave_on = 1'b1;
        issue(1'b0, 10'h004, 32'h0, 1'b0, 32'hDEAD_BEEF);
        wait_rsp(2);
        take_rsp(0);

        // Backpressure for 5 cycles with the ack held one extra cycle
        stretch = 1'b1;
        issue(1'b0, 10'h004, 32'h0, 1'b0, 32'hDEAD_BEEF);
        wait_rsp(2);
        take_rsp(5);
        stretch = 1'b0;
        @(negedge clk);
        chk("no_second_bus_cycle", {wb_cyc_o, req_ready}, 2'b01);

        // Reset in the middle of a bus cycle
        slave_on = 1'b0;
        issue(1'b0, 10'h030, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("in_bus_before_reset", {wb_cyc_o, dbg_state}, 3'b101);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_drops_bus", {wb_cyc_o, wb_stb_o, rsp_valid, busy}, 4'b0000);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b1;
        slave_on = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", req_ready, 1);
        issue(1'b0, 10'h004, 32'h0, 1'b0, 32'hDEAD_BEEF);
        wait_rsp(2);
        take_rsp(0);

        // Random write/read-back pairs
        for (int k = 0; k < 3; k++) begin
            ra = AW'($urandom_range(64, 1023));
            rd = $urandom;
            issue(1'b1, ra, rd, 1'b0, 32'h0);
            wait_rsp(2);
            take_rsp(0);
            issue(1'b0, ra, 32'h0, 1'b0, rd);
            wait_rsp(2);
            take_rsp($urandom_range(0, 3));
        end

        // dut4: ack on the 4th BUS cycle races the watchdog, ack wins
        @(negedge clk);
        r4_valid = 1'b1; r4_we = 1'b0; r4_adr = 10'h005;
        exp_q.push_back({1'b0, 32'hCAFE_F00D});
        @(negedge clk);
        r4_valid = 1'b0;
        chk("d4_cyc_after_accept", {w4_cyc, w4_stb, r4_ready}, 3'b110);
        repeat (3) @(negedge clk);
        chk("d4_still_in_bus", {w4_cyc, p4_valid}, 2'b10);
        w4_ack = 1'b1; w4_dat_i = 32'hCAFE_F00D;
        @(negedge clk);
        w4_ack = 1'b0; w4_dat_i = 32'h0;
        chk("d4_race_rsp_valid", {p4_valid, w4_cyc}, 2'b10);
        chk("d4_race_rsp_err", p4_err, exp_q[0][DW]);
        chk("d4_race_rsp_dat", p4_dat, exp_q[0][DW-1:0]);
        void'(exp_q.pop_front());
        p4_ready = 1'b1;
        @(negedge clk);
        p4_ready = 1'b0;
        chk("d4_back_to_idle", {r4_ready, p4_valid}, 2'b10);

        // dut4: no ack, watchdog ends the cycle after 4 cycles; late ack ignored
        r4_valid = 1'b1; r4_we = 1'b1; r4_adr = 10'h006; r4_dat = 32'h1234_5678;
        @(negedge clk);
        r4_valid = 1'b0;
        n = 0;
        while (!p4_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("d4_timeout_cycles", n, 4);
        chk("d4_timeout_rsp", {p4_valid, p4_err, w4_cyc}, 3'b110);
        chk("d4_timeout_dat", p4_dat, 0);
        w4_ack = 1'b1; w4_dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        w4_ack = 1'b0;
        chk("d4_late_ack_ignored", {p4_valid, p4_err, w4_cyc, r4_ready}, 4'b1100);
        chk("d4_late_ack_dat", p4_dat, 0);
        p4_ready = 1'b1;
        @(negedge clk);
        p4_ready = 1'b0;
        chk("d4_idle_after_timeout", {r4_ready, p4_valid, p4_err, busy4}, 4'b1000);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
